// File: rtl/watch_time_core_pkg.sv
// Shared definitions for the watch time core: setting-state encoding, field limits and the
// binary-to-BCD split used on the display path.
package watch_time_core_pkg;

    typedef enum logic [2:0] {
        StRun     = 3'd0,
        StSetMin  = 3'd1,
        StSetHr   = 3'd2,
        StSetAmin = 3'd3,
        StSetAhr  = 3'd4
    } state_e;

    localparam int unsigned MaxSec  = 59;
    localparam int unsigned MaxMin  = 59;
    localparam int unsigned MaxHour = 23;

    // Compare-subtract split of a 0..79 value into {tens, units}.
    function automatic logic [7:0] bin2bcd(input logic [6:0] v);
        logic [6:0] r;
        logic [3:0] t;
        r = v;
        t = 4'd0;
        if (r >= 7'd40) begin r = r - 7'd40; t = t + 4'd4; end
        if (r >= 7'd20) begin r = r - 7'd20; t = t + 4'd2; end
        if (r >= 7'd10) begin r = r - 7'd10; t = t + 4'd1; end
        return {t, r[3:0]};
    endfunction

endpackage

// File: rtl/watch_time_core_counter.sv
// Modulo-(MAX+1) up/down counter for one time or alarm field; carry flags an increment at MAX.
module watch_time_core_counter #(
    parameter int unsigned MAX = 59,
    parameter int unsigned W   = 6
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_inc,
    input  logic         i_dec,
    input  logic         i_clr,
    output logic [W-1:0] o_val,
    output logic         o_carry
);

    logic [W-1:0] r_val;
    logic         w_at_max;

    assign w_at_max = (r_val == W'(MAX));
    assign o_carry  = i_inc & w_at_max;
    assign o_val    = r_val;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_val <= '0;
        end else if (i_clr) begin
            r_val <= '0;
        end else if (i_inc && !i_dec) begin
            r_val <= w_at_max ? '0 : r_val + W'(1);
        end else if (i_dec && !i_inc) begin
            r_val <= (r_val == '0) ? W'(MAX) : r_val - W'(1);
        end
    end

endmodule

// File: rtl/watch_time_core.sv
// Watch timekeeping core: second divider, HH:MM:SS time, one alarm, key-driven setting FSM
// and registered BCD display outputs with optional 12-hour mapping.
module watch_time_core
    import watch_time_core_pkg::*;
#(
    parameter int unsigned CLK_FRE   = 50_000_000,
    parameter int unsigned ALARM_SEC = 30
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       key_dec,
    input  logic       mode_12h,
    input  logic       alarm_en,
    output logic [3:0] hour_h_o,
    output logic [3:0] hour_l_o,
    output logic [3:0] minutes_h_o,
    output logic [3:0] minutes_l_o,
    output logic [3:0] seconds_h_o,
    output logic [3:0] seconds_l_o,
    output logic       pm_o,
    output logic       second_led,
    output logic       alarm_o,
    output logic [2:0] state_flag
);

    localparam int unsigned      TickW    = (CLK_FRE > 1) ? $clog2(CLK_FRE) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(CLK_FRE - 1);
    localparam logic [TickW-1:0] TickHalf = TickW'(CLK_FRE / 2 - 1);

    state_e           r_state, w_state_next;
    logic [TickW-1:0] r_tick_cnt;
    logic             r_led, r_alarm, r_match, r_pm;
    logic [5:0]       r_alarm_cnt;
    logic [23:0]      r_disp;

    logic       w_sec_tick, w_any_key, w_key_ok, w_advance, w_edit_inc, w_edit_dec;
    logic       w_enter_min, w_time_run, w_min_tick, w_match, w_pm;
    logic       w_sec_carry, w_min_carry, w_hour_carry, w_amin_carry, w_ahour_carry;
    logic       w_unused_carry;
    logic [5:0] w_sec, w_min, w_amin, w_disp_min, w_disp_sec;
    logic [4:0] w_hour, w_ahour, w_disp_hour, w_hour_shown;

    assign w_sec_tick = (r_tick_cnt == TickLast);
    assign w_any_key  = key_mode | key_inc | key_dec;
    // A ringing alarm swallows every key press.
    assign w_key_ok    = ~(r_alarm & w_any_key);
    assign w_advance   = w_key_ok & key_mode;
    assign w_edit_inc  = w_key_ok & ~key_mode & key_inc & ~key_dec;
    assign w_edit_dec  = w_key_ok & ~key_mode & key_dec & ~key_inc;
    assign w_enter_min = w_advance & (r_state == StRun);
    assign w_time_run  = w_sec_tick & ~w_enter_min &
                         (r_state inside {StRun, StSetAmin, StSetAhr});
    assign w_min_tick  = w_time_run & w_sec_carry;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= StRun;
            r_tick_cnt <= '0;
            r_led      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tick_cnt <= w_sec_tick ? '0 : r_tick_cnt + TickW'(1);
            if (r_tick_cnt == TickHalf) begin
                r_led <= 1'b1;
            end else if (w_sec_tick) begin
                r_led <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_advance) begin
            case (r_state)
                StRun:     w_state_next = StSetMin;
                StSetMin:  w_state_next = StSetHr;
                StSetHr:   w_state_next = StSetAmin;
                StSetAmin: w_state_next = StSetAhr;
                default:   w_state_next = StRun;
            endcase
        end
    end

    watch_time_core_counter #(.MAX(MaxSec), .W(6)) u_sec (
        .clk(clk), .rstn(rstn), .i_inc(w_time_run), .i_dec(1'b0), .i_clr(w_enter_min),
        .o_val(w_sec), .o_carry(w_sec_carry)
    );
    watch_time_core_counter #(.MAX(MaxMin), .W(6)) u_min (
        .clk(clk), .rstn(rstn),
        .i_inc(w_min_tick | (w_edit_inc & (r_state == StSetMin))),
        .i_dec(w_edit_dec & (r_state == StSetMin)), .i_clr(1'b0),
        .o_val(w_min), .o_carry(w_min_carry)
    );
    watch_time_core_counter #(.MAX(MaxHour), .W(5)) u_hour (
        .clk(clk), .rstn(rstn),
        .i_inc((w_min_tick & w_min_carry) | (w_edit_inc & (r_state == StSetHr))),
        .i_dec(w_edit_dec & (r_state == StSetHr)), .i_clr(1'b0),
        .o_val(w_hour), .o_carry(w_hour_carry)
    );
    watch_time_core_counter #(.MAX(MaxMin), .W(6)) u_amin (
        .clk(clk), .rstn(rstn), .i_inc(w_edit_inc & (r_state == StSetAmin)),
        .i_dec(w_edit_dec & (r_state == StSetAmin)), .i_clr(1'b0),
        .o_val(w_amin), .o_carry(w_amin_carry)
    );
    watch_time_core_counter #(.MAX(MaxHour), .W(5)) u_ahour (
        .clk(clk), .rstn(rstn), .i_inc(w_edit_inc & (r_state == StSetAhr)),
        .i_dec(w_edit_dec & (r_state == StSetAhr)), .i_clr(1'b0),
        .o_val(w_ahour), .o_carry(w_ahour_carry)
    );

    assign w_unused_carry = ^{w_hour_carry, w_amin_carry, w_ahour_carry};

    assign w_match = (r_state == StRun) & alarm_en & (w_sec == 6'd0) &
                     (w_min == w_amin) & (w_hour == w_ahour);

    // Arm only on the rising edge of the match so a dismissed alarm stays quiet for the rest
    // of the matching second.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_alarm     <= 1'b0;
            r_alarm_cnt <= 6'd0;
            r_match     <= 1'b0;
        end else begin
            r_match <= w_match;
            if (r_alarm) begin
                if (!alarm_en || w_any_key) begin
                    r_alarm     <= 1'b0;
                    r_alarm_cnt <= 6'd0;
                end else if (w_sec_tick) begin
                    r_alarm_cnt <= r_alarm_cnt - 6'd1;
                    if (r_alarm_cnt == 6'd1) begin
                        r_alarm <= 1'b0;
                    end
                end
            end else if (w_match && !r_match) begin
                r_alarm     <= 1'b1;
                r_alarm_cnt <= 6'(ALARM_SEC);
            end
        end
    end

    always_comb begin
        w_disp_hour  = w_hour;
        w_disp_min   = w_min;
        w_disp_sec   = w_sec;
        w_pm         = 1'b0;
        if (r_state == StSetAmin || r_state == StSetAhr) begin
            w_disp_hour = w_ahour;
            w_disp_min  = w_amin;
            w_disp_sec  = 6'd0;
        end
        w_hour_shown = w_disp_hour;
        if (mode_12h) begin
            w_pm = (w_disp_hour >= 5'd12);
            if (w_disp_hour == 5'd0) begin
                w_hour_shown = 5'd12;
            end else if (w_disp_hour > 5'd12) begin
                w_hour_shown = w_disp_hour - 5'd12;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_disp <= 24'd0;
            r_pm   <= 1'b0;
        end else begin
            r_disp <= {bin2bcd({2'b00, w_hour_shown}), bin2bcd({1'b0, w_disp_min}),
                       bin2bcd({1'b0, w_disp_sec})};
            r_pm   <= w_pm;
        end
    end

    assign {hour_h_o, hour_l_o, minutes_h_o, minutes_l_o, seconds_h_o, seconds_l_o} = r_disp;
    assign pm_o       = r_pm;
    assign second_led = r_led;
    assign alarm_o    = r_alarm;
    assign state_flag = r_state;

endmodule

// File: tb/tb_watch_time_core.sv
// Bench for watch_time_core: directed scenarios then random key traffic, every cycle compared
// against a seconds-of-day reference model.
module tb_watch_time_core;

    localparam int unsigned CLK_FRE   = 10;
    localparam int unsigned ALARM_SEC = 3;

    logic       clk = 1'b0, rstn = 1'b0;
    logic       key_mode = 1'b0, key_inc = 1'b0, key_dec = 1'b0;
    logic       mode_12h = 1'b0, alarm_en = 1'b0;
    logic [3:0] hour_h_o, hour_l_o, minutes_h_o, minutes_l_o, seconds_h_o, seconds_l_o;
    logic       pm_o, second_led, alarm_o;
    logic [2:0] state_flag;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: time as seconds of day, alarm as minutes of day.
    int          m_tod, m_alm, m_st, m_tick, m_left;
    bit          m_ring, m_mprev, m_led, m_was_tick;
    logic [29:0] m_exp;

    watch_time_core #(.CLK_FRE(CLK_FRE), .ALARM_SEC(ALARM_SEC)) dut (
        .clk(clk), .rstn(rstn), .key_mode(key_mode), .key_inc(key_inc), .key_dec(key_dec),
        .mode_12h(mode_12h), .alarm_en(alarm_en),
        .hour_h_o(hour_h_o), .hour_l_o(hour_l_o), .minutes_h_o(minutes_h_o),
        .minutes_l_o(minutes_l_o), .seconds_h_o(seconds_h_o), .seconds_l_o(seconds_l_o),
        .pm_o(pm_o), .second_led(second_led), .alarm_o(alarm_o), .state_flag(state_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] dut_bus();
        return {hour_h_o, hour_l_o, minutes_h_o, minutes_l_o, seconds_h_o, seconds_l_o,
                pm_o, second_led, alarm_o, state_flag};
    endfunction

    function automatic logic [23:0] digits();
        return {hour_h_o, hour_l_o, minutes_h_o, minutes_l_o, seconds_h_o, seconds_l_o};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_tod = 0; m_alm = 0; m_st = 0; m_tick = 0; m_left = 0;
        m_ring = 0; m_mprev = 0; m_led = 0; m_was_tick = 0;
        m_exp = '0;
    endfunction

    function automatic void model_edge();
        int v, h, mi, s, dh, d, st0, th, tm, ts, ah, am;
        bit tick, anyk, match, ring0, entered, pm;
        st0   = m_st;
        ring0 = m_ring;
        v  = (st0 == 3 || st0 == 4) ? m_alm * 60 : m_tod;
        h  = v / 3600;
        mi = (v / 60) % 60;
        s  = v % 60;
        dh = h;
        pm = 0;
        if (mode_12h) begin
            dh = (h % 12 == 0) ? 12 : h % 12;
            pm = (h >= 12);
        end
        tick = (m_tick == CLK_FRE - 1);
        m_was_tick = tick;
        anyk  = key_mode | key_inc | key_dec;
        match = (st0 == 0) && alarm_en && (m_tod % 60 == 0) && (m_tod / 60 == m_alm);
        if (ring0) begin
            if (!alarm_en || anyk) m_ring = 0;
            else if (tick) begin
                m_left--;
                if (m_left == 0) m_ring = 0;
            end
        end else if (match && !m_mprev) begin
            m_ring = 1;
            m_left = ALARM_SEC;
        end
        m_mprev = match;
        entered = 0;
        if (!(ring0 && anyk)) begin
            d  = key_inc ? 1 : -1;
            th = m_tod / 3600; tm = (m_tod / 60) % 60; ts = m_tod % 60;
            ah = m_alm / 60;   am = m_alm % 60;
            if (key_mode) begin
                m_st = (m_st + 1) % 5;
                if (m_st == 1) begin
                    m_tod   = m_tod - ts;
                    entered = 1;
                end
            end else if (key_inc != key_dec) begin
                case (st0)
                    1: m_tod = th * 3600 + ((tm + d + 60) % 60) * 60 + ts;
                    2: m_tod = ((th + d + 24) % 24) * 3600 + tm * 60 + ts;
                    3: m_alm = ah * 60 + (am + d + 60) % 60;
                    4: m_alm = ((ah + d + 24) % 24) * 60 + am;
                    default: ;
                endcase
            end
        end
        if (tick && (st0 == 0 || st0 == 3 || st0 == 4) && !entered) m_tod = (m_tod + 1) % 86400;
        m_tick = (m_tick + 1) % CLK_FRE;
        m_led  = (m_tick >= CLK_FRE / 2);
        m_exp  = {4'(dh / 10), 4'(dh % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10),
                  pm, m_led, m_ring, 3'(m_st)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        key_dec  = 1'b0;
        check("outputs", dut_bus(), m_exp);
    endtask

    task automatic press(input logic km, input logic ki, input logic kd);
        key_mode = km;
        key_inc  = ki;
        key_dec  = kd;
        cyc();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic run_until_tod(input int target, input int limit, input string tag);
        int c = 0;
        while (m_tod != target && c < limit) begin
            cyc();
            c++;
        end
        check(tag, 32'(m_tod == target), 32'd1);
    endtask

    task automatic wait_ticks(input int n, input string tag);
        int seen = 0;
        for (int c = 0; c < 4 * CLK_FRE * n && seen < n; c++) begin
            cyc();
            if (m_was_tick) seen++;
        end
        check(tag, 32'(seen), 32'(n));
    endtask

    initial begin
        model_reset();
        #12;
        check("reset_outputs", 32'(dut_bus()), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Free run one minute, then preset 23:59:xx and cross midnight.
        idle(601);
        check("t1_one_minute", 32'(digits()), 32'h000100);
        press(1, 0, 0); press(0, 0, 1); press(0, 0, 1);
        press(1, 0, 0); press(0, 0, 1);
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
        run_until_tod(86399, 700, "t1_reach_235959");
        cyc();
        check("t1_preset", 32'(digits()), 32'h235959);
        run_until_tod(0, 20, "t1_reach_wrap");
        cyc();
        check("t1_wrap", 32'(digits()), 32'h000000);

        // Minute wrap around 59/0 and hour wrap down from 0.
        press(1, 0, 0); press(0, 0, 1); press(0, 0, 1);
        press(0, 1, 0); press(0, 1, 0); press(0, 1, 0); press(0, 0, 1);
        idle(1);
        check("t2_min_sec", 32'({minutes_h_o, minutes_l_o, seconds_h_o, seconds_l_o}), 32'h0000);
        check("t2_state", 32'(state_flag), 32'd1);
        press(1, 0, 0); press(0, 0, 1);
        idle(1);
        check("t2_hour", 32'({hour_h_o, hour_l_o}), 32'h23);

        // 12-hour mapping.
        mode_12h = 1'b1;
        idle(1);
        check("t3_h23", 32'({hour_h_o, hour_l_o, 3'b000, pm_o}), 32'h111);
        press(0, 1, 0); idle(1);
        check("t3_h0", 32'({hour_h_o, hour_l_o, 3'b000, pm_o}), 32'h120);
        repeat (12) press(0, 1, 0);
        idle(1);
        check("t3_h12", 32'({hour_h_o, hour_l_o, 3'b000, pm_o}), 32'h121);
        press(0, 1, 0); idle(1);
        check("t3_h13", 32'({hour_h_o, hour_l_o, 3'b000, pm_o}), 32'h011);
        mode_12h = 1'b0;

        // Alarm at 00:02, time 00:01:00.
        repeat (13) press(0, 0, 1);
        press(1, 0, 0); press(0, 1, 0); press(0, 1, 0);
        idle(1);
        check("t4_alarm_disp", 32'(digits()), 32'h000200);
        check("t4_alarm_state", 32'(state_flag), 32'd3);
        press(1, 0, 0); press(1, 0, 0);
        press(1, 0, 0); press(0, 1, 0);
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
        alarm_en = 1'b1;
        run_until_tod(120, 700, "t4_reach_0200");
        check("t4_pre", 32'(alarm_o), 32'd0);
        cyc();
        check("t4_rise", 32'({alarm_o, digits()}), 32'h1000200);
        wait_ticks(2, "t4_tick_budget_a");
        check("t4_hold", 32'(alarm_o), 32'd1);
        wait_ticks(1, "t4_tick_budget_b");
        check("t4_fall", 32'(alarm_o), 32'd0);

        // Repeat at 00:03 and dismiss with a key.
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0); press(0, 1, 0);
        press(1, 0, 0); press(1, 0, 0);
        run_until_tod(180, 700, "t4b_reach_0300");
        cyc();
        check("t4b_rise", 32'(alarm_o), 32'd1);
        press(0, 1, 0);
        check("t4b_dismiss", 32'({alarm_o, state_flag}), 32'h0);
        idle(5);
        check("t4b_no_retrigger", 32'(alarm_o), 32'd0);
        alarm_en = 1'b0;

        // Simultaneous keys.
        press(1, 1, 0); idle(1);
        check("t5_mode_inc", 32'({state_flag, minutes_h_o, minutes_l_o, seconds_h_o,
                                  seconds_l_o}), 32'h10300);
        press(0, 1, 1); idle(1);
        check("t5_inc_dec", 32'({minutes_h_o, minutes_l_o}), 32'h03);
        press(1, 0, 1); idle(1);
        check("t5_mode_dec", 32'({state_flag, digits()}), 32'h2000300);

        // Asynchronous reset mid-second in SET_HR.
        for (int c = 0; c < 20 && m_tick != 5; c++) cyc();
        #2;
        rstn = 1'b0;
        #1;
        check("t6_async", 32'(dut_bus()), 32'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        cyc();
        check("t6_state", 32'(state_flag), 32'd0);

        // Random key traffic.
        alarm_en = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 63) == 0) mode_12h = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 127) == 0) alarm_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) begin
                logic [2:0] k;
                k = 3'($urandom_range(1, 7));
                press(k[2], k[1], k[0]);
            end else begin
                cyc();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
